// File: rtl/exe_stage_mul.sv
// -----------------------------------------------------------------------------
// exe_stage_mul
//   Execute stage of the ARM pipeline. It has three parts:
//   - a single-cycle ALU path with operand forwarding and Val2 generation,
//   - branch-target generation,
//   - an iterative shift-and-add multiplier for MUL/MLA. While the multiplier
//     runs, it stalls the upstream pipeline.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   forward1/forward2          operand source: 01 mem_result, 10 exe_result,
//                              anything else selects valRn / valRm
//   exec_cmd                   ALU command
//   mem_read, mem_write, imm   Val2 mode controls
//   s                          update flags for this instruction
//   mul, mla                   multiply / multiply-accumulate request
//   flush                      kill the current instruction
//   PC_in                      PC for branch-target generation
//   valRn, valRm, valRa        register operands
//   exe_result, mem_result     forwarded results
//   shift_operand              shifter operand
//   signed_imm                 branch offset in words
//   ALU_result                 ALU result, or the product when mul_valid=1
//   branchAddress              PC_in + (sign-extended signed_imm << 2)
//   NZCV                       registered flags {N,Z,C,V}
//   stall                      upstream must hold
//   mul_valid                  ALU_result carries a finished product
// -----------------------------------------------------------------------------
module exe_stage_mul #(
  parameter int WIDTH   = 32,
  parameter int IMM_W   = 24,
  parameter int MUL_BPC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       forward1,
  input  logic [1:0]       forward2,
  input  logic [3:0]       exec_cmd,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             imm,
  input  logic             s,
  input  logic             mul,
  input  logic             mla,
  input  logic             flush,
  input  logic [WIDTH-1:0] PC_in,
  input  logic [WIDTH-1:0] valRn,
  input  logic [WIDTH-1:0] valRm,
  input  logic [WIDTH-1:0] valRa,
  input  logic [WIDTH-1:0] exe_result,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [11:0]      shift_operand,
  input  logic [IMM_W-1:0] signed_imm,
  output logic [WIDTH-1:0] ALU_result,
  output logic [WIDTH-1:0] branchAddress,
  output logic [3:0]       NZCV,
  output logic             stall,
  output logic             mul_valid
);

  // ALU command encoding
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam int ITERS = WIDTH / MUL_BPC;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mul_state_e;

  // ---------------------------------------------------------------------------
  // Operand forwarding
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] src1, src2;

  always_comb begin
    unique case (forward1)
      2'b01:   src1 = mem_result;
      2'b10:   src1 = exe_result;
      default: src1 = valRn;
    endcase
    unique case (forward2)
      2'b01:   src2 = mem_result;
      2'b10:   src2 = exe_result;
      default: src2 = valRm;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Val2 generator
  // ---------------------------------------------------------------------------
  // The rotate amount is reduced modulo WIDTH. This lets narrow datapaths
  // accept the full ARM rotate / shift field.
  function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x,
                                           input int unsigned r);
    logic [2*WIDTH-1:0] xx;
    int unsigned        re;
    re = r % WIDTH;
    xx = {x, x} >> re;
    return xx[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] val2;
  logic [4:0]       sh_amt;
  logic [1:0]       sh_type;

  assign sh_amt  = shift_operand[11:7];
  assign sh_type = shift_operand[6:5];

  always_comb begin
    if (mem_read || mem_write) begin
      // Load/store offset: 12-bit unsigned immediate.
      val2 = WIDTH'(shift_operand);
    end else if (imm) begin
      // 8-bit immediate, rotated right by twice the 4-bit rotate field.
      val2 = ror(WIDTH'(shift_operand[7:0]), int'({shift_operand[11:8], 1'b0}));
    end else begin
      unique case (sh_type)
        2'b00:   val2 = src2 << sh_amt;
        2'b01:   val2 = src2 >> sh_amt;
        2'b10:   val2 = $signed(src2) >>> sh_amt;
        default: val2 = ror(src2, int'(sh_amt));
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_res, add_b;
  logic [WIDTH:0]   sum_ext;
  logic             add_cin, is_arith, alu_c, alu_v;
  logic [3:0]       alu_flags;
  logic [3:0]       nzcv_q, nzcv_d;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    // Logical ops pass the incoming C and V through.
    alu_res  = '0;
    add_b    = val2;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    alu_c    = nzcv_q[1];
    alu_v    = nzcv_q[0];
    unique case (exec_cmd)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_AND: alu_res = src1 & val2;
      CMD_ORR: alu_res = src1 | val2;
      CMD_EOR: alu_res = src1 ^ val2;
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin is_arith = 1'b1; add_cin = nzcv_q[1]; end
      CMD_SUB: begin is_arith = 1'b1; add_b = ~val2; add_cin = 1'b1; end
      CMD_SBC: begin is_arith = 1'b1; add_b = ~val2; add_cin = nzcv_q[1]; end
      default: alu_res = '0;
    endcase
    // Subtraction is a + ~b + cin, so C is the ARM "no borrow" flag.
    sum_ext = {1'b0, src1} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    if (is_arith) begin
      alu_res = sum_ext[WIDTH-1:0];
      alu_c   = sum_ext[WIDTH];
      alu_v   = (src1[WIDTH-1] == add_b[WIDTH-1]) &&
                (sum_ext[WIDTH-1] != src1[WIDTH-1]);
    end
  end

  assign alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};

  // ---------------------------------------------------------------------------
  // Branch target
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] imm_sext;

  assign imm_sext      = {{(WIDTH-IMM_W){signed_imm[IMM_W-1]}}, signed_imm};
  assign branchAddress = PC_in + (imm_sext << 2);

  // ---------------------------------------------------------------------------
  // Iterative multiplier
  //   a: multiplicand, shifted left each cycle
  //   b: multiplier, shifted right; low MUL_BPC bits are consumed each cycle
  //   sum: preloaded with the accumulator, so DONE holds A*B + acc directly
  // ---------------------------------------------------------------------------
  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, pp;
  logic             s_q, s_d;

  // Partial product A * B[MUL_BPC-1:0], truncated to WIDTH bits.
  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (b_q[j]) pp = pp + (a_q << j);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    s_d       = s_q;
    nzcv_d    = nzcv_q;
    stall     = 1'b0;
    mul_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          if (mul) begin
            stall   = 1'b1;
            state_d = ST_BUSY;
            a_d     = src2;
            b_d     = src1;
            sum_d   = mla ? valRa : '0;
            s_d     = s;
            cnt_d   = ITERS_C;
          end else if (s) begin
            nzcv_d = alu_flags;
          end
        end
      end

      ST_BUSY: begin
        stall = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          sum_d = sum_q + pp;
          a_d   = a_q << MUL_BPC;
          b_d   = b_q >> MUL_BPC;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // A mul still high here belongs to the finishing instruction, so
        // the FSM always returns to IDLE and never re-accepts it.
        state_d = ST_IDLE;
        if (!flush) begin
          mul_valid = 1'b1;
          if (s_q) nzcv_d = {sum_q[WIDTH-1], (sum_q == '0), nzcv_q[1:0]};
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments. Then every register
  // samples the values from before the edge, whatever order the
  // assignments appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= 1'b0;
      nzcv_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      nzcv_q  <= nzcv_d;
    end
  end

  assign ALU_result = mul_valid ? sum_q : alu_res;
  assign NZCV       = nzcv_q;

endmodule

// File: tb/tb_exe_stage_mul.sv
// -----------------------------------------------------------------------------
// tb_exe_stage_mul
//   Directed testbench for exe_stage_mul. It drives a default 32-bit instance
//   and a 16-bit instance with MUL_BPC=4. All expected values are hand-derived
//   constants. Inputs change 2 time units after a rising edge. Outputs are
//   checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_exe_stage_mul;

  localparam logic [3:0] C_MOV = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0100;

  logic        clk = 1'b0;
  logic        rst;

  // 32-bit instance
  logic [1:0]  fwd1, fwd2;
  logic [3:0]  cmd;
  logic        mem_rd, mem_wr, imm, s, mul, mla, flush;
  logic [31:0] pc, rn, rm, ra, exe_res, mem_res;
  logic [11:0] shop;
  logic [23:0] simm;
  logic [31:0] alu, br;
  logic [3:0]  nzcv;
  logic        stall, mvalid;

  // 16-bit instance
  logic [1:0]  w_fwd1, w_fwd2;
  logic [3:0]  w_cmd;
  logic        w_mem_rd, w_mem_wr, w_imm, w_s, w_mul, w_mla, w_flush;
  logic [15:0] w_pc, w_rn, w_rm, w_ra, w_exe_res, w_mem_res;
  logic [11:0] w_shop;
  logic [7:0]  w_simm;
  logic [15:0] w_alu, w_br;
  logic [3:0]  w_nzcv;
  logic        w_stall, w_mvalid;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  exe_stage_mul dut (
    .clk(clk), .rst(rst), .forward1(fwd1), .forward2(fwd2), .exec_cmd(cmd),
    .mem_read(mem_rd), .mem_write(mem_wr), .imm(imm), .s(s), .mul(mul),
    .mla(mla), .flush(flush), .PC_in(pc), .valRn(rn), .valRm(rm), .valRa(ra),
    .exe_result(exe_res), .mem_result(mem_res), .shift_operand(shop),
    .signed_imm(simm), .ALU_result(alu), .branchAddress(br), .NZCV(nzcv),
    .stall(stall), .mul_valid(mvalid)
  );

  exe_stage_mul #(.WIDTH(16), .IMM_W(8), .MUL_BPC(4)) dut16 (
    .clk(clk), .rst(rst), .forward1(w_fwd1), .forward2(w_fwd2),
    .exec_cmd(w_cmd), .mem_read(w_mem_rd), .mem_write(w_mem_wr), .imm(w_imm),
    .s(w_s), .mul(w_mul), .mla(w_mla), .flush(w_flush), .PC_in(w_pc),
    .valRn(w_rn), .valRm(w_rm), .valRa(w_ra), .exe_result(w_exe_res),
    .mem_result(w_mem_res), .shift_operand(w_shop), .signed_imm(w_simm),
    .ALU_result(w_alu), .branchAddress(w_br), .NZCV(w_nzcv),
    .stall(w_stall), .mul_valid(w_mvalid)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Counts cycles from the accept cycle (n=0) until mul_valid is seen. Every
  // cycle before DONE must stall. NZCV is checked mid-BUSY.
  // With perturb=1, forwarding inputs are scrambled during the run.
  task automatic wait_done(input bit perturb, input logic [3:0] hold_flags,
                           output int n);
    int stall_low;
    stall_low = 0;
    n = 0;
    while (!mvalid && n < 40) begin
      if (!stall) stall_low++;
      if (n == 5) check("busy_nzcv_hold", 32'(nzcv), 32'(hold_flags));
      tick();
      if (perturb) begin
        rn = $urandom; rm = $urandom; ra = $urandom;
        exe_res = $urandom; mem_res = $urandom;
        fwd1 = 2'b10; fwd2 = 2'b01;
      end
      #1;
      n++;
    end
    check("stall_held_until_done", 32'(stall_low), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int saw_valid;

    rst = 1'b1;
    {fwd1, fwd2, cmd, mem_rd, mem_wr, imm, s, mul, mla, flush} = '0;
    {pc, rn, rm, ra, exe_res, mem_res} = '0;
    shop = '0; simm = '0;
    {w_fwd1, w_fwd2, w_cmd, w_mem_rd, w_mem_wr, w_imm, w_s, w_mul, w_mla,
     w_flush} = '0;
    {w_pc, w_rn, w_rm, w_ra, w_exe_res, w_mem_res} = '0;
    w_shop = '0; w_simm = '0;

    // Reset
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("reset_nzcv", 32'(nzcv), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_mul_valid", 32'(mvalid), 32'h0);

    // ADD 5+7 with flag update; then SUB 5-7 sets N, clears C (borrow)
    cmd = C_ADD; rn = 32'd5; rm = 32'd7; s = 1'b1;
    #1 check("add_result", alu, 32'd12);
    tick();
    check("add_nzcv", 32'(nzcv), 32'b0000);
    cmd = C_SUB;
    #1 check("sub_result", alu, 32'hFFFF_FFFE);
    tick();
    check("sub_nzcv", 32'(nzcv), 32'b1000);
    s = 1'b0;

    // Forwarding
    cmd = C_ADD; fwd1 = 2'b10; exe_res = 32'h10; fwd2 = 2'b01; mem_res = 32'h3;
    rn = 32'h100; rm = 32'h20;
    #1 check("fwd_add", alu, 32'h13);
    cmd = C_SUB;
    #1 check("fwd_sub", alu, 32'hD);
    cmd = C_ADD; fwd1 = 2'b11; fwd2 = 2'b11;
    #1 check("fwd_code11_regs", alu, 32'h120);
    fwd1 = 2'b00; fwd2 = 2'b00;

    // Val2 modes: rotated immediate, register LSL #4, memory offset
    cmd = C_MOV; imm = 1'b1; shop = 12'h1FF;
    #1 check("val2_imm_ror", alu, 32'hC000_003F);
    imm = 1'b0; shop = 12'h200;
    #1 check("val2_lsl4", alu, 32'h200);
    cmd = C_ADD; mem_rd = 1'b1; shop = 12'h804;
    #1 check("val2_mem_offset", alu, 32'h904);
    mem_rd = 1'b0; shop = '0;

    // Set NZCV=0011: 0x80000000 + 0x80000001 carries and overflows
    rn = 32'h8000_0000; rm = 32'h8000_0001; s = 1'b1;
    #1 check("cv_add_result", alu, 32'h1);
    tick();
    check("cv_nzcv", 32'(nzcv), 32'b0011);

    // Flush in IDLE suppresses the flag update
    cmd = C_SUB; rn = 32'd5; rm = 32'd7; flush = 1'b1;
    tick();
    check("idle_flush_nzcv", 32'(nzcv), 32'b0011);
    flush = 1'b0; s = 1'b0; cmd = C_ADD;

    // MUL 0xFFFFFFFF * 2
    rn = 32'hFFFF_FFFF; rm = 32'd2; s = 1'b1; mul = 1'b1;
    #1 check("mul_accept_stall", 32'(stall), 32'h1);
    wait_done(1'b0, 4'b0011, n);
    check("mul_latency", 32'(n), 32'd17);
    check("mul_product", alu, 32'hFFFF_FFFE);
    check("mul_valid_done", 32'(mvalid), 32'h1);
    check("mul_done_stall", 32'(stall), 32'h0);
    tick();
    mul = 1'b0; s = 1'b0;
    #1;
    check("mul_nzcv", 32'(nzcv), 32'b1011);
    check("mul_valid_after", 32'(mvalid), 32'h0);

    // MLA 6*7 + 0xFFFFFFD6 = 0, with inputs scrambled during BUSY
    rn = 32'd6; rm = 32'd7; ra = 32'hFFFF_FFD6; mla = 1'b1; mul = 1'b1; s = 1'b1;
    #1;
    wait_done(1'b1, 4'b1011, n);
    check("mla_latency", 32'(n), 32'd17);
    check("mla_product", alu, 32'h0);
    tick();
    mul = 1'b0; mla = 1'b0; s = 1'b0; fwd1 = 2'b00; fwd2 = 2'b00;
    #1 check("mla_nzcv", 32'(nzcv), 32'b0111);

    // Flush at BUSY cycle 5, then issue a new MUL immediately
    rn = 32'd3; rm = 32'd4; mul = 1'b1; s = 1'b1;
    saw_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      #1;
      if (mvalid) saw_valid++;
    end
    flush = 1'b1;
    #1 if (mvalid) saw_valid++;
    tick();
    flush = 1'b0; rn = 32'h1234; rm = 32'h10; s = 1'b0;
    #1 check("flush_no_mul_valid", 32'(saw_valid), 32'd0);
    check("reissue_stall", 32'(stall), 32'h1);
    wait_done(1'b0, 4'b0111, n);
    check("reissue_latency", 32'(n), 32'd17);
    check("reissue_product", alu, 32'h12340);

    // Back-to-back: new MUL in the cycle after DONE
    tick();
    rn = 32'd3; rm = 32'd5; s = 1'b1;
    #1 check("flush_nzcv_unchanged", 32'(nzcv), 32'b0111);
    check("b2b_accept_stall", 32'(stall), 32'h1);
    wait_done(1'b0, 4'b0111, n);
    check("b2b_latency", 32'(n), 32'd17);
    check("b2b_product", alu, 32'd15);

    // Reset mid-BUSY
    tick();
    check("b2b_nzcv", 32'(nzcv), 32'b0011);
    rn = 32'd9; rm = 32'd9;
    repeat (3) tick();
    rst = 1'b1; mul = 1'b0; s = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rst_busy_stall", 32'(stall), 32'h0);
    check("rst_busy_nzcv", 32'(nzcv), 32'h0);
    check("rst_busy_mul_valid", 32'(mvalid), 32'h0);

    // Branch target
    pc = 32'h100; simm = 24'hFF_FFFF;
    #1 check("branch_neg1", br, 32'hFC);
    simm = 24'h00_0004;
    #1 check("branch_pos4", br, 32'h110);

    // 16-bit, 4 bits per cycle: 0xFF * 0x101 = 0xFFFF, DONE at cycle 5
    w_pc = 16'h100; w_simm = 8'hFF;
    #1 check("w_branch_neg1", 32'(w_br), 32'hFC);
    w_rn = 16'hFF; w_rm = 16'h101; w_s = 1'b1; w_mul = 1'b1;
    #1 check("w_accept_stall", 32'(w_stall), 32'h1);
    n = 0;
    while (!w_mvalid && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("w_latency", 32'(n), 32'd5);
    check("w_product", 32'(w_alu), 32'hFFFF);
    tick();
    w_mul = 1'b0; w_s = 1'b0;
    #1 check("w_nzcv", 32'(w_nzcv), 32'b1000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/exe_stage_mul.md
# exe_stage_mul

Parametrised execute stage for the ARM pipeline. It keeps the single-cycle ALU path with operand forwarding and branch-target generation, and adds an iterative multiplier for MUL/MLA. The multiplier stalls the upstream pipeline while it runs. Flags are registered on the rising edge of the single system clock. The block sits between the ID/EX and EX/MEM pipeline registers and drives the hazard unit's stall input.

## Interface
Parameters:
- WIDTH, 32, datapath width (≥8, even)
- IMM_W, 24, branch immediate width (< WIDTH)
- MUL_BPC, 2, multiplier bits retired per cycle; must divide WIDTH

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- forward1, forward2  in  2  operand source select: 01 mem_result, 10 exe_result, else register value
- exec_cmd  in  4  ALU command (existing ALU encoding)
- mem_read, mem_write, imm, s  in  1 each  Val2 mode controls and flag-update enable
- mul  in  1  instruction is a multiply; held high by upstream while stall=1
- mla  in  1  accumulate (MLA); valid with mul
- flush  in  1  kill the current instruction
- PC_in, valRn, valRm, valRa, exe_result, mem_result  in  WIDTH each
- shift_operand  in  12  shifter operand
- signed_imm  in  IMM_W  branch offset, in words
- ALU_result  out  WIDTH  ALU result, or product when mul_valid=1
- branchAddress  out  WIDTH  branch target
- NZCV  out  4  registered flags
- stall  out  1  upstream must hold
- mul_valid  out  1  ALU_result carries the finished product this cycle

## Operation
- Operand select: src1 comes from forward1 over {valRn, mem_result, exe_result}. src2 comes from forward2 over {valRm, mem_result, exe_result}. Code 11 selects the register value.
- Non-multiply path is combinational:
  - val2 = Val2Generator(src2, shift_operand, imm, mem_read|mem_write).
  - ALU_result = ALU(exec_cmd, src1, val2, carry-in = NZCV[1]).
- branchAddress = PC_in + (sign-extended signed_imm << 2), truncated to WIDTH.
- Multiplier FSM has three states: IDLE, BUSY, DONE.
  - IDLE, mul=1, flush=0: latch A=src2 (unshifted), B=src1, acc=valRa if mla else 0, and s. Go to BUSY and load the iteration counter with WIDTH/MUL_BPC.
  - BUSY: each cycle, add A·B[MUL_BPC-1:0] into the partial sum, shift A left and B right by MUL_BPC, and decrement the counter. At count 1, go to DONE.
  - DONE: product = (A_orig·B_orig + acc) mod 2^WIDTH. mul_valid=1, ALU_result=product. Then go to IDLE.
- Operands are latched at accept. Forwarding-input changes during BUSY have no effect.
- stall = mul & ~flush in IDLE, or any cycle in BUSY. stall=0 in DONE, so upstream advances during DONE. mul still high in DONE is the finishing instruction and never starts a new multiply.
- NZCV updates:
  - Non-multiply cycle in IDLE with s=1 and mul=0: NZCV <= ALU status.
  - DONE with latched s=1: N <= product[WIDTH-1], Z <= (product==0). C and V are preserved.
  - All other cycles, including IDLE-accept and BUSY: NZCV holds.
- flush=1: in IDLE, it suppresses accept and the NZCV update. In BUSY or DONE, the FSM returns to IDLE next edge with no NZCV update and mul_valid forced to 0 that cycle.

## Timing
- Reset values: FSM=IDLE, NZCV=0000, stall=0, mul_valid=0, counter=0, latched operands=0. A reset mid-multiply aborts it; no flag update.
- ALU and branch path: 0-cycle combinational. Flags are visible the cycle after the instruction.
- Multiply latency, from accept edge to the DONE cycle: WIDTH/MUL_BPC + 1 cycles. With defaults, accept at cycle 0, BUSY cycles 1–16, DONE cycle 17.
- stall is high for cycles 0 through WIDTH/MUL_BPC, and low in DONE.
- A back-to-back multiply can be accepted in the cycle after DONE; there is no bubble beyond IDLE.
- flush and rst in the same cycle: rst wins.

## Test plan
- Reset, then ADD (cmd per ALU encoding), valRn=5, valRm=7, imm=0, s=1: ALU_result=12, NZCV=0000 next cycle. Assert rst mid-BUSY: stall=0 and NZCV=0000 next cycle.
- Forwarding: forward1=10 with exe_result=0x10, forward2=01 with mem_result=0x3: ALU path uses 0x10 and 0x3. Code 11 selects valRn/valRm.
- MUL: src1=0xFFFFFFFF, src2=2, s=1, prior NZCV=0011: stall for 17 cycles, DONE gives ALU_result=0xFFFFFFFE, mul_valid=1, NZCV=1011.
- MLA: 6·7 + valRa=0xFFFFFFD6 gives 0, so Z=1. Change forwarded inputs during BUSY: result unchanged.
- flush at BUSY cycle 5: IDLE next cycle, mul_valid never asserts, NZCV unchanged. Issue a new MUL immediately: accepted.
- Branch: PC_in=0x100, signed_imm=0xFFFFFF (−1): branchAddress=0xFC. Repeat with WIDTH=16, MUL_BPC=4: 0xFF·0x101=0xFFFF, latency 5 cycles.
